// File: rtl/pulse_generator_pkg.sv
// Shared rpm configuration: clock rate and bus widths used by the generator and the counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pulse_generator_pkg;

  localparam int CFG_CLK_RATE  = 50_000_000;  // clock frequency in Hz, also the period dividend
  localparam int CFG_RPM_WIDTH = 16;          // width of the rate command
  localparam int CFG_DIV_WIDTH = 32;          // width of period and phase counters

  // Shortest period that still produces a square wave (clk/2).
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_generator_if.sv
// Rate command / pulse output bundle between a rate source and the pulse generator.
// Latency: n/a (wires only).
// Backpressure: none; pulse_rate_change is a level-toggle strobe, no handshake back.
// Ports: pulse_rate, pulse_rate_change (master -> slave); pulse, busy, active (slave -> master).
interface pulse_generator_if
  import pulse_generator_pkg::*;
#(
  parameter int RPM_WIDTH = CFG_RPM_WIDTH
);

  logic [RPM_WIDTH-1:0] pulse_rate;
  logic                 pulse_rate_change;
  logic                 pulse;
  logic                 busy;
  logic                 active;

  modport master (
    output pulse_rate, pulse_rate_change,
    input  pulse, busy, active
  );

  modport slave (
    input  pulse_rate, pulse_rate_change,
    output pulse, busy, active
  );

endinterface

// File: rtl/pulse_generator_rate_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle; divide-by-zero yields 0.
// Latency: start sampled at edge T, done/quotient valid after edge T+DIV_WIDTH.
// Backpressure: start is ignored while busy; caller must hold requests until busy is low.
// Ports: clk, rst, start, dividend, divisor in; busy, done (1-cycle), quotient out.
module rate_divider
  import pulse_generator_pkg::*;
#(
  parameter int DIV_WIDTH = CFG_DIV_WIDTH,
  parameter int DEN_WIDTH = CFG_RPM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DEN_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient
);

  localparam int CW = $clog2(DIV_WIDTH + 1);

  logic [DIV_WIDTH-1:0] rem;
  logic [DIV_WIDTH-1:0] quo;   // holds remaining dividend bits, quotient shifts in from the bottom
  logic [DEN_WIDTH-1:0] den;
  logic [CW-1:0]        steps;
  logic [DIV_WIDTH-1:0] den_ext;
  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH-1:0] trial;
  logic                 fits;

  always_comb begin
    den_ext = {{(DIV_WIDTH - DEN_WIDTH){1'b0}}, den};
    shifted = {rem, quo[DIV_WIDTH-1]};
    fits    = shifted >= {1'b0, den_ext};
    // When fits, the true difference is below den, so the low bits are exact.
    trial   = shifted[DIV_WIDTH-1:0] - den_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      den   <= '0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy && start) begin
        rem   <= '0;
        quo   <= dividend;
        den   <= divisor;
        steps <= CW'(DIV_WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        rem   <= fits ? trial : shifted[DIV_WIDTH-1:0];
        quo   <= {quo[DIV_WIDTH-2:0], fits};
        steps <= steps - CW'(1);
        if (steps == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // A zero divisor runs the full schedule but reports 0.
  assign quotient = (den == '0) ? '0 : quo;

endmodule

// File: rtl/pulse_generator.sv
// Square pulse train at a commanded rate (pulses/s); period = CLK_RATE / rate, clamped to >= 2.
// Latency: toggle seen at edge T -> period applied at T+DIV_WIDTH+1 when idle, first pulse high after T+DIV_WIDTH+2.
// Backpressure: none; requests during a division park in a single last-value-wins slot.
// Ports: clk, rst (async, active-high); bus.slave carries pulse_rate/pulse_rate_change in, pulse/busy/active out.
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int CLK_RATE  = CFG_CLK_RATE,
  parameter int RPM_WIDTH = CFG_RPM_WIDTH,
  parameter int DIV_WIDTH = CFG_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  pulse_generator_if.slave bus
);

  logic                 chg_q;
  logic                 req;
  logic                 start;
  logic                 pend;
  logic [RPM_WIDTH-1:0] pend_rate;
  logic [RPM_WIDTH-1:0] div_rate;
  logic                 cur_zero;
  logic                 div_busy;
  logic                 div_done;
  logic [DIV_WIDTH-1:0] quo;
  logic [DIV_WIDTH-1:0] new_period;
  logic [DIV_WIDTH-1:0] period;
  logic [DIV_WIDTH-1:0] nxt_period;
  logic                 nxt_vld;
  logic [DIV_WIDTH-1:0] cnt;
  logic                 active_q;
  logic                 pulse_q;
  logic                 wrap;

  // Any level change on the strobe is a request.
  assign req   = bus.pulse_rate_change != chg_q;
  // A fresh request supersedes the parked one (last value wins).
  assign start = !div_busy && (req || pend);
  assign div_rate = req ? bus.pulse_rate : pend_rate;

  // Rate 0 gives period 0 (stop); any other small quotient is clamped to clk/2.
  assign new_period = cur_zero ? '0
                    : (quo < DIV_WIDTH'(MIN_PERIOD)) ? DIV_WIDTH'(MIN_PERIOD) : quo;

  assign wrap = active_q && (cnt == period - DIV_WIDTH'(1));

  rate_divider #(
    .DIV_WIDTH (DIV_WIDTH),
    .DEN_WIDTH (RPM_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (DIV_WIDTH'(CLK_RATE)),
    .divisor  (div_rate),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quo)
  );

  // Request capture: toggle history, pending slot, zero-rate flag of the running division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q     <= 1'b0;
      pend      <= 1'b0;
      pend_rate <= '0;
      cur_zero  <= 1'b0;
    end else begin
      chg_q <= bus.pulse_rate_change;
      if (req && div_busy) begin
        pend      <= 1'b1;
        pend_rate <= bus.pulse_rate;
      end else if (start) begin
        pend <= 1'b0;
      end
      if (start) cur_zero <= (div_rate == '0);
    end
  end

  // Period application and phase counter. While running, a new period only
  // lands on a wrap so every emitted pulse is full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period     <= '0;
      nxt_period <= '0;
      nxt_vld    <= 1'b0;
      cnt        <= '0;
      active_q   <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      if (div_done && !active_q) begin
        period   <= new_period;
        cnt      <= '0;
        active_q <= (new_period != '0);
        nxt_vld  <= 1'b0;
      end else if (wrap) begin
        cnt <= '0;
        if (div_done) begin
          period   <= new_period;
          active_q <= (new_period != '0);
          nxt_vld  <= 1'b0;
        end else if (nxt_vld) begin
          period   <= nxt_period;
          active_q <= (nxt_period != '0);
          nxt_vld  <= 1'b0;
        end
      end else begin
        if (active_q) cnt <= cnt + DIV_WIDTH'(1);
        if (div_done) begin
          nxt_period <= new_period;
          nxt_vld    <= 1'b1;
        end
      end
      pulse_q <= active_q && (cnt < (period >> 1));
    end
  end

  assign bus.pulse  = pulse_q;
  assign bus.busy   = div_busy;
  assign bus.active = active_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator at CLK_RATE=1000: run-length scoreboard on pulse and busy.
// Latency: n/a.
// Backpressure: n/a.
module tb_pulse_generator;

  logic clk;
  logic rst;

  pulse_generator_if #(.RPM_WIDTH(16)) bus();

  pulse_generator #(
    .CLK_RATE  (1000),
    .RPM_WIDTH (16),
    .DIV_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected run lengths, consumed in order by the monitor.
  int exp_busy[$];
  int exp_high[$];
  int exp_low[$];
  int busy_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: measure each completed busy/high/low run and compare with the queues.
  int  busy_run, high_run, low_run;
  bit  prev_busy, prev_pulse, have_fall;
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0; high_run = 0; low_run = 0;
      prev_busy = 1'b0; prev_pulse = 1'b0; have_fall = 1'b0;
    end else begin
      if (bus.busy) busy_run++;
      else if (prev_busy) begin
        busy_cnt++;
        if (exp_busy.size() > 0) check("busy_len", busy_run, exp_busy.pop_front());
        busy_run = 0;
      end
      prev_busy = bus.busy;

      if (bus.pulse) begin
        if (!prev_pulse) begin
          if (have_fall && exp_low.size() > 0) check("low_len", low_run, exp_low.pop_front());
          low_run = 0;
        end
        high_run++;
      end else begin
        if (prev_pulse) begin
          if (exp_high.size() > 0) check("high_len", high_run, exp_high.pop_front());
          high_run = 0;
          have_fall = 1'b1;
        end
        low_run++;
      end
      prev_pulse = bus.pulse;
      if (!bus.active) have_fall = 1'b0;
    end
  end

  task automatic toggle(input int rate);
    @(posedge clk); #1;
    bus.pulse_rate = 16'(rate);
    bus.pulse_rate_change = ~bus.pulse_rate_change;
  endtask

  task automatic do_reset(input logic chg_level);
    rst = 1'b1;
    bus.pulse_rate_change = chg_level;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_rise(input string name, input int max);
    int n;
    n = 0;
    while (!bus.pulse && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, int'(bus.pulse), 1);
  endtask

  task automatic check_empty(input string name);
    check(name, exp_busy.size() + exp_high.size() + exp_low.size(), 0);
  endtask

  task automatic push_busy(input int n);  exp_busy.push_back(n); endtask
  task automatic push_hl(input int h, input int l);
    exp_high.push_back(h);
    exp_low.push_back(l);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, act_lat, seen, b0;

    // Reset state, with the strobe already high: one request after release.
    rst = 1'b1;
    bus.pulse_rate = 16'd10;
    bus.pulse_rate_change = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse",  int'(bus.pulse),  0);
    check("rst_busy",   int'(bus.busy),   0);
    check("rst_active", int'(bus.active), 0);

    // Rate 10 -> period 100 (50/50); busy 32 cycles; first rise at T+34.
    push_busy(32);
    push_hl(50, 50);
    push_hl(50, 50);
    rst = 1'b0;
    @(posedge clk); #1;           // edge T: request seen, division starts
    check("busy_start", int'(bus.busy), 1);
    lat = 0; act_lat = -1;
    while (!bus.pulse && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.active && act_lat < 0) act_lat = lat;
    end
    check("active_latency", act_lat, 33);
    check("first_rise_latency", lat, 34);
    repeat (250) @(posedge clk);
    #1;
    check("r10_active", int'(bus.active), 1);
    check_empty("r10_leftover");

    // Rate 3 -> period 333: 166 high, 167 low.
    do_reset(1'b0);
    push_busy(32);
    push_hl(166, 167);
    push_hl(166, 167);
    toggle(3);
    repeat (800) @(posedge clk);
    check_empty("r3_leftover");

    // Rate 10 running, rate 20 toggled mid-high: 100-cycle period finishes, then 25/25.
    do_reset(1'b0);
    push_busy(32);
    push_busy(32);
    push_hl(50, 50);
    push_hl(25, 25);
    push_hl(25, 25);
    toggle(10);
    wait_rise("r10_rise", 100);
    repeat (10) @(posedge clk);
    toggle(20);
    repeat (300) @(posedge clk);
    check_empty("r20_leftover");

    // Rate 900 -> clamp to period 2, then rate 0 stops the output.
    do_reset(1'b0);
    push_busy(32);
    push_hl(1, 1);
    push_hl(1, 1);
    toggle(900);
    repeat (45) @(posedge clk);
    #1;
    check("r900_active", int'(bus.active), 1);
    push_busy(32);
    toggle(0);
    repeat (45) @(posedge clk);
    #1;
    check("r0_active", int'(bus.active), 0);
    check("r0_pulse",  int'(bus.pulse),  0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.pulse) seen++;
    end
    check("r0_stays_low", seen, 0);
    check_empty("r900_leftover");

    // Rates 5, 7, 8 on consecutive cycles: 5 then 8 divided (200 then 125).
    do_reset(1'b0);
    b0 = busy_cnt;
    push_busy(32);
    push_busy(32);
    push_hl(100, 100);
    push_hl(62, 63);
    toggle(5);
    toggle(7);
    toggle(8);
    repeat (500) @(posedge clk);
    check("divisions_run", busy_cnt - b0, 2);
    check_empty("pend_leftover");

    // Reset mid-division.
    do_reset(1'b0);
    toggle(10);
    repeat (10) @(posedge clk);
    #1;
    check("busy_mid_div", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("rst_div_busy",   int'(bus.busy),   0);
    check("rst_div_active", int'(bus.active), 0);
    check("rst_div_pulse",  int'(bus.pulse),  0);
    do_reset(1'b0);
    seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.pulse || bus.busy) seen++;
    end
    check("quiet_after_div_rst", seen, 0);

    // Reset mid-pulse.
    toggle(10);
    wait_rise("rst_pulse_rise", 100);
    repeat (5) @(posedge clk);
    #1;
    check("pulse_before_rst", int'(bus.pulse), 1);
    rst = 1'b1;
    #1;
    check("rst_pulse_low",    int'(bus.pulse),  0);
    check("rst_pulse_active", int'(bus.active), 0);
    do_reset(1'b0);
    seen = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (bus.pulse || bus.busy) seen++;
    end
    check("quiet_after_pulse_rst", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Synthesises a square pulse train at a commanded rate in pulses per second. It is the transmit-side counterpart of the pulse-rate counter. It takes the same rate/toggle pair that the counter produces and drives a `pulse` output that the counter can measure. Uses:
- loopback self-test of the tachometer path;
- bench stimulus;
- simulated-sensor output on the board.

## Interface
- `CLK_RATE`, 50_000_000, clock frequency in Hz; also the dividend for the period calculation.
- `RPM_WIDTH`, 16, width of the rate command.
- `DIV_WIDTH`, 32, width of the period and phase counters.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pulse_rate`  in  RPM_WIDTH  commanded rate, pulses/s; sampled only on a toggle.
- `pulse_rate_change`  in  1  toggle strobe; any level change means a new `pulse_rate` is valid.
- `pulse`  out  1  registered pulse train.
- `busy`  out  1  high while a period division is in progress.
- `active`  out  1  high while a non-zero period is being generated.

## Operation
- **Reset:** `pulse`, `busy` and `active` are 0. The period register, phase counter, pending flag and toggle history are all 0.
- **Toggle detection:**
  - The history flop `chg_q` samples `pulse_rate_change` every cycle.
  - A request is raised when `pulse_rate_change != chg_q`.
  - The history flop is 0 after reset, so an input already held at 1 produces one request after reset deasserts.
- **Request while idle** (`busy`=0): latch `pulse_rate` and start the divider.
- **Request while busy:**
  - Latch `pulse_rate` into the single pending slot and set pending.
  - A later request overwrites the slot; the last value wins.
  - When the current division completes, the pending value starts the next division on the following cycle.
- **Divider:**
  - Restoring, unsigned, one quotient bit per cycle.
  - Computes `period = CLK_RATE / rate`, floored, DIV_WIDTH bits.
- **Rate 0:**
  - No division is run; the result is period 0 on the same schedule.
  - Period 0 sets `active`=0 and `pulse` low within 1 cycle of the apply point.
- **Clamp:** a quotient below 2 (rate > CLK_RATE/2) is clamped to 2, i.e. a clk/2 square wave.
- **Applying a new period:**
  - If `active`=0: applied on the cycle after division completes; the phase counter restarts at 0.
  - If `active`=1: held as the next period and applied when the phase counter wraps (period-1 → 0). This keeps the output glitch-free and every emitted pulse full-length.
- **Generation:**
  - The phase counter `cnt` counts 0..period-1 and then wraps.
  - `pulse` is high for `cnt < period>>1`, low otherwise.
  - An odd period therefore gives a high time of floor(P/2) and a low time of ceil(P/2).

## Timing
- A toggle visible at edge T starts division at T: `busy` rises after T.
- The quotient is ready after edge T+DIV_WIDTH; `busy` falls at the same edge.
- Idle apply: `cnt`=0 and `active`=1 after T+DIV_WIDTH+1; the first rising `pulse` follows at T+DIV_WIDTH+2 (output registered).
- Output period: exactly P cycles, with no drift.
- Busy apply: the new period is loaded at the first wrap at or after T+DIV_WIDTH+1.
- Back-to-back requests: the pending division starts the cycle after `busy` falls. `busy` may drop for a single cycle between divisions.
- Reset mid-division or mid-pulse: all state clears immediately (asynchronous) and `pulse` goes low. A division in progress or a pending request is discarded.
- Rate unchanged but toggled: the period is recomputed and re-applied at the next wrap, with no phase disturbance.

## Structure
- `CLK_RATE`, `RPM_WIDTH` and `DIV_WIDTH` live in the shared rpm configuration include, beside the averaging constants. They are shared with the counter.
- Sub-module `rate_divider`:
  - start/done handshake.
  - DIV_WIDTH-cycle iterative unsigned divide.
  - divide-by-zero returns 0.
- The top level holds:
  - toggle detect;
  - pending slot;
  - clamp;
  - next-period register;
  - phase counter;
  - output flop.

## Test plan
Simulation uses `CLK_RATE`=1000.
- Rate 10, one toggle → `busy` high 32 cycles, then period 100: `pulse` high 50, low 50, repeating; `active`=1.
- Rate 3 → period 333: high 166, low 167 cycles.
- Rate 10 running, then rate 20 toggled mid-high-phase → the current 100-cycle period completes unaltered, then 50-cycle periods (25/25).
- Rate 900 → quotient 1 clamped to 2: `pulse` alternates every cycle. Then rate 0 → `pulse` low and `active`=0 after the apply point.
- Three toggles (rates 5, 7, 8) within 5 cycles → only rates 5 and 8 are ever divided; final period 125.
- Reset asserted mid-division and mid-pulse → all outputs 0 immediately; no pulse after release until a new toggle.
- Loopback into the pulse-rate counter at rate 10 → the counter reports 10 or 11 each second after one settling second. This is a boundary effect of the counter's sampling window.
